// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the 3-input truth-table sweeper.
package truth_table_pkg;

    localparam int NUM_INPUTS = 3;
    localparam int NUM_ROWS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FINISH
    } sweep_state_e;

    typedef logic [NUM_ROWS-1:0]   code_t;
    typedef logic [NUM_INPUTS-1:0] row_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable settle down-counter; zero marks the last cycle of a row window.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 rows of a 3-input gate and captures its truth-table code.
// Optional double-pass stability check: define SWEEPER_VERIFY_EN.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [NUM_INPUTS-1:0] stim,
    input  logic                  resp,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_ROWS-1:0]   table_out
`ifdef SWEEPER_VERIFY_EN
    ,
    output logic                  unstable
`endif
);

`ifdef SWEEPER_VERIFY_EN
    localparam int SHADOW_W = 2 * NUM_ROWS - 1;
`else
    localparam int SHADOW_W = NUM_ROWS - 1;
`endif

    sweep_state_e state_q, state_d;

    row_t                row_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [SHADOW_W:0]   shadow_next;
    logic                launch;
    logic                timer_load;
    logic                timer_zero;
    logic                sample;
    logic                last_row;

`ifdef SWEEPER_VERIFY_EN
    logic pass_q;
    assign last_row = (&row_q) && pass_q;
`else
    assign last_row = &row_q;
`endif

    // The newest sample enters at bit 0, so row 0 ends up in the MSB.
    assign shadow_next = {shadow_q, resp};

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .zero(timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        timer_load = 1'b0;
        sample     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    launch     = 1'b1;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    sample = 1'b1;
                    if (last_row) begin
                        state_d = FINISH;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            shadow_q  <= '0;
            table_out <= '0;
`ifdef SWEEPER_VERIFY_EN
            pass_q    <= 1'b0;
            unstable  <= 1'b0;
`endif
        end else begin
            if (launch) begin
                row_q <= '0;
`ifdef SWEEPER_VERIFY_EN
                pass_q <= 1'b0;
`endif
            end else if (sample && !last_row) begin
                row_q <= row_q + NUM_INPUTS'(1);
`ifdef SWEEPER_VERIFY_EN
                if (&row_q) begin
                    pass_q <= 1'b1;
                end
`endif
            end
            if (sample) begin
                shadow_q <= shadow_next[SHADOW_W-1:0];
            end
            // Result lands on FINISH entry so it is valid alongside done.
            if (sample && last_row) begin
`ifdef SWEEPER_VERIFY_EN
                table_out <= shadow_next[2*NUM_ROWS-1:NUM_ROWS];
                unstable  <= shadow_next[2*NUM_ROWS-1:NUM_ROWS]
                             != shadow_next[NUM_ROWS-1:0];
`else
                table_out <= shadow_next;
`endif
            end
        end
    end

    assign busy = (state_q == SETTLE);
    assign done = (state_q == FINISH);
    assign stim = busy ? row_q : '0;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential characterizer for 3-input logic gates: on request it drives all eight input combinations onto a gate under test, waits a programmable settle time for each, samples the gate's single-bit response and assembles the 8-bit truth-table code (e.g. 0x63). It is the reading counterpart to the combinational 3-input gate modules. It sits beside a gate instance in characterization and self-test harnesses: it drives the gate's inputs and reads back its output.

## Interface
- SETTLE_CYCLES, 4, cycles each stimulus is held before its response is sampled; legal range 1..255
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; ignored while busy=1
- stim  output  3  stimulus to gate under test, ordered {in1,in2,in3}
- resp  input  1  gate-under-test output (already synchronous to clk)
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when table_out is updated
- table_out  output  8  last completed truth-table code
- unstable  output  1  present only with SWEEPER_VERIFY_EN; see Configuration

## Operation
- Reset values: stim=3'b000, busy=0, done=0, table_out=8'h00, unstable=0; FSM in IDLE.
- FSM states: IDLE, SETTLE, FINISH.
  - IDLE -> SETTLE on start=1. Clear the row index to 0 and load the settle timer with SETTLE_CYCLES-1.
  - SETTLE: stim = row index. When the timer reaches 0, sample resp into the shadow register and advance the row.
    - If the sampled row was 7, go to FINISH.
    - Otherwise reload the timer and remain in SETTLE.
  - FINISH: copy the shadow register to table_out, pulse done, return to IDLE.
- Bit mapping: the response to row i lands in table_out[7-i].
  - Row 000 is the MSB and row 111 is the LSB.
  - Reading the responses in row order 000..111 as a binary string gives the hex code directly.
- table_out updates atomically in FINISH only. It holds its value through later sweeps until the next FINISH.
- stim returns to 3'b000 in IDLE and FINISH.
- start while busy=1 is ignored; no queueing.
- Reset asserted mid-sweep: on the next edge, abort to IDLE with all reset values, including table_out=0.
- Row index is 3 bits plus an end-of-sweep flag. Row 7 must not wrap to row 0 inside a sweep.

## Timing
- Cycle 0: start sampled high.
- Cycles 1 .. 8·S (S = SETTLE_CYCLES):
  - busy=1.
  - Row i is driven during cycles 1+i·S .. (i+1)·S.
  - resp for row i is sampled at the edge ending cycle (i+1)·S.
- Cycle 8·S+1: FSM in FINISH, done=1, table_out valid, busy=0.
- A new start is accepted in cycle 8·S+2 or later.
- S=1: one row per cycle, total latency 9 cycles from start to done.
- resp is sampled only in the last cycle of each row's window; glitches earlier in the window are ignored.

## Configuration
- SWEEPER_VERIFY_EN defined:
  - Each sweep runs two consecutive passes (16 rows); done occurs at cycle 16·S+1.
  - table_out takes the pass-1 code.
  - unstable is set to 1 in FINISH if the pass-2 code differs from pass 1; otherwise it is cleared to 0.
  - unstable holds its value until the next FINISH or reset.
- SWEEPER_VERIFY_EN undefined: single pass as specified above; the unstable port and the second shadow register are absent.

## Structure
- Shared package truth_table_pkg:
  - sweep-state enum (IDLE, SETTLE, FINISH);
  - NUM_INPUTS=3, NUM_ROWS=8;
  - code typedef (8-bit truth-table code).
- Sub-module settle_timer: loadable down-counter with a zero flag, sized by $clog2(SETTLE_CYCLES+1), with synchronous reset.

## Test plan
- Behavioural 0x63 gate model on resp, S=4, start at cycle 0 -> stim steps 0..7 every 4 cycles; done at cycle 33; table_out=8'h63; busy low at cycle 33.
- Constant-1 gate, S=1 -> done at cycle 9, table_out=8'hFF; then a constant-0 gate -> table_out=8'h00.
- start pulsed again during cycles 5 and 20 of a sweep -> ignored; exactly one done; timing unchanged.
- rst asserted at cycle 12 of a sweep with a 0x63 gate -> next cycle stim=0, busy=0, table_out=8'h00, no done; a fresh start then yields 8'h63.
- Glitching resp (inverted on the first cycle of each row), S=3 -> table_out unaffected, equals the stable gate code.
- With SWEEPER_VERIFY_EN, resp flipped only during pass 2, row 5 -> table_out=pass-1 code, unstable=1, done at cycle 16·S+1. With a stable gate -> unstable=0.
